obj_sprite_renderer: RTL and testbench
======================================

Name: obj_sprite_renderer

Overview:
Consumes the five packed object descriptors (p_obj1..p_obj5) produced by the central game logic and draws them into the VGA pixel stream.
- Snapshots all descriptors once per frame at vsync, so a frame never tears.
- Hit-tests each pixel against every object's bounding box and fetches sprite colour from an external synchronous sprite ROM.
- Emits a pixel and an object-coverage flag, with the syncs delayed to match.
- Sits between game logic and the final background/object colour mux.

Parameters:
OBJ_SIZE, 20, sprite width and height in pixels (must be <= 32)
TRANSPARENT, 12'h000, ROM colour treated as "no object pixel"
LATENCY, 3, fixed pipeline depth in clocks (documentation constant; RTL is built for 3)

Ports:
clock  in  1  pixel clock
reset_n  in  1  synchronous, active-low reset
hcount  in  11  current pixel column
vcount  in  10  current line
hsync  in  1  VGA hsync, aligned with hcount
vsync  in  1  VGA vsync, aligned with hcount
blank  in  1  VGA blank, aligned with hcount
p_obj1..p_obj5  in  26 each  descriptor: [25:23] frame, [22:21] identity, [20:10] hpos, [9:0] vpos; all-zero = absent
rom_addr  out  15  {identity[1:0], frame[2:0], row[4:0], col[4:0]}
rom_data  in  12  RGB444; valid one clock after rom_addr
pixel  out  12  object colour, 0 when obj_on=0
obj_on  out  1  opaque object pixel present
hsync_out  out  1  hsync delayed LATENCY
vsync_out  out  1  vsync delayed LATENCY
blank_out  out  1  blank delayed LATENCY
obj_count  out  3  number of non-zero descriptors in the current snapshot (0..5)

Behaviour:
- Reset (reset_n=0 at clock edge):
  - snapshot registers, pixel, obj_on, rom_addr, obj_count all <= 0;
  - delayed syncs <= 0;
  - vsync edge detector cleared.
  - Takes effect mid-frame; the next rising vsync after release reloads the snapshot.
- Snapshot:
  - vsync_prev is registered each clock.
  - On vsync=1 && vsync_prev=0, all five descriptors are copied into snapshot registers and obj_count is recomputed.
  - The snapshot holds until the next rising edge; input changes in between are ignored.
- Stage 1 (hit test, per object i):
  - enable = |snap_i;
  - dx = hcount - hpos and dy = vcount - vpos, computed 12 bits wide unsigned;
  - hit_i = enable && hcount >= hpos && dx < OBJ_SIZE && vcount >= vpos && dy < OBJ_SIZE.
  - No wrap: an object at hpos 2040 never appears at the left edge.
  - Priority: the lowest index with hit_i wins. A transparent pixel of the winner still hides lower-priority objects inside its box.
  - Registers: hit_any; rom_addr from the winner's identity, frame, dy[4:0], dx[4:0] (rom_addr = 0 when no hit); sync/blank delay stage 1.
- Stage 2: the ROM returns rom_data. Register hit_any and syncs into stage 2.
- Stage 3:
  - obj_on <= hit2 && !blank2 && rom_data != TRANSPARENT;
  - pixel <= obj_on_next ? rom_data : 0;
  - syncs delayed to stage 3.
- Latency: exactly 3 clocks from an hcount/vcount sample to the matching pixel, obj_on and *_out.
- Blank: obj_on is forced 0 while blank is high, even if an object box overlaps blanking coordinates.
- Snapshot edge coinciding with an active pixel: that pixel's stage-1 compare uses the old snapshot; the new snapshot is used from the next clock.
- Identity values 2 and 3 address the ROM like any other; no special handling.

Decomposition:
- Shared package: descriptor field positions (FRAME_MSB/LSB, ID_MSB/LSB, HPOS_MSB/LSB, VPOS_MSB/LSB), ROM address width (15) and colour width (12), so game logic and renderer agree on the format.
- One sub-module: obj_hit_test. It is purely combinational and instantiated 5 times; per descriptor it outputs hit, dx[4:0] and dy[4:0].

Test Plan:
1. Reset / empty snapshot:
   - stimulus: reset_n low 2 clocks; all p_obj=0; one full frame;
   - required: obj_on=0, pixel=0 and obj_count=0 throughout; *_out equal inputs delayed 3.
2. Single object:
   - stimulus: p_obj1 = {frame 2, id 0, hpos 100, vpos 300}; vsync rising edge; hcount=105, vcount=307;
   - required: rom_addr = {2'd0, 3'd2, 5'd7, 5'd5} one clock later; model ROM returns 12'hF80; pixel=12'hF80 and obj_on=1 exactly 3 clocks after the sample.
3. Box edges:
   - stimulus: same object; hcount=119 / vcount=319 (inside) and hcount=120, hcount=99, vcount=320 (outside);
   - required: obj_on=1 only at the inside coordinates.
4. Overlap priority:
   - stimulus: p_obj2 and p_obj4 at the same position with different identities;
   - required: rom_addr carries obj2's identity. When ROM returns TRANSPARENT, obj_on=0 (obj4 is not shown).
5. Snapshot hold:
   - stimulus: change p_obj1 hpos 100 -> 50 mid-frame;
   - required: rendering stays at 100 until after the next vsync rising edge, then moves to 50; obj_count is stable within the frame.
6. Blank and reset mid-frame:
   - stimulus: object overlapping the blank region → obj_on=0 there;
   - stimulus: assert reset_n=0 at hcount 500 → next clock pixel=0 and obj_count=0; no object drawn until a vsync edge after release.

Source files
------------

// File: rtl/obj_sprite_renderer_pkg.sv
// Shared object-descriptor layout and sprite ROM geometry used by game logic and the renderer.
package obj_sprite_renderer_pkg;

    localparam int unsigned NUM_OBJ   = 5;
    localparam int unsigned DESC_W    = 26;
    localparam int unsigned FRAME_MSB = 25;
    localparam int unsigned FRAME_LSB = 23;
    localparam int unsigned ID_MSB    = 22;
    localparam int unsigned ID_LSB    = 21;
    localparam int unsigned HPOS_MSB  = 20;
    localparam int unsigned HPOS_LSB  = 10;
    localparam int unsigned VPOS_MSB  = 9;
    localparam int unsigned VPOS_LSB  = 0;
    localparam int unsigned ROM_AW    = 15;
    localparam int unsigned COLOR_W   = 12;

    function automatic logic [2:0] count_present(input logic [NUM_OBJ-1:0] present);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            n = n + 3'(present[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/obj_sprite_renderer_hit_test.sv
// Combinational bounding-box test of one pixel against one object descriptor.
module obj_hit_test
    import obj_sprite_renderer_pkg::*;
#(
    parameter int unsigned OBJ_SIZE = 20
) (
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic [DESC_W-1:0] desc,
    output logic              hit,
    output logic [4:0]        dx,
    output logic [4:0]        dy
);

    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic [11:0] dx_full;
    logic [11:0] dy_full;

    assign hpos    = desc[HPOS_MSB:HPOS_LSB];
    assign vpos    = desc[VPOS_MSB:VPOS_LSB];
    assign dx_full = {1'b0, hcount} - {1'b0, hpos};
    assign dy_full = {2'b00, vcount} - {2'b00, vpos};

    // Explicit >= checks keep boxes near the right/bottom edge from wrapping around.
    assign hit = (|desc) && (hcount >= hpos) && (dx_full < 12'(OBJ_SIZE))
                         && (vcount >= vpos) && (dy_full < 12'(OBJ_SIZE));
    assign dx  = dx_full[4:0];
    assign dy  = dy_full[4:0];

endmodule

// File: rtl/obj_sprite_renderer.sv
// Renders five per-frame-snapshotted sprite objects into the VGA pixel stream via an external sync ROM.
module obj_sprite_renderer
    import obj_sprite_renderer_pkg::*;
#(
    parameter int unsigned         OBJ_SIZE    = 20,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = 12'h000,
    parameter int unsigned         LATENCY     = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [10:0]         hcount,
    input  logic [9:0]          vcount,
    input  logic                hsync,
    input  logic                vsync,
    input  logic                blank,
    input  logic [DESC_W-1:0]   p_obj1,
    input  logic [DESC_W-1:0]   p_obj2,
    input  logic [DESC_W-1:0]   p_obj3,
    input  logic [DESC_W-1:0]   p_obj4,
    input  logic [DESC_W-1:0]   p_obj5,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [COLOR_W-1:0]  rom_data,
    output logic [COLOR_W-1:0]  pixel,
    output logic                obj_on,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                blank_out,
    output logic [2:0]          obj_count
);

    logic [DESC_W-1:0]  obj_in [NUM_OBJ];
    logic [DESC_W-1:0]  snap   [NUM_OBJ];
    logic [NUM_OBJ-1:0] present_in;
    logic [NUM_OBJ-1:0] hit;
    logic [4:0]         dx [NUM_OBJ];
    logic [4:0]         dy [NUM_OBJ];
    logic               vsync_prev;
    logic               hit_any;
    logic [ROM_AW-1:0]  win_addr;
    logic               hit1;
    logic               hit2;
    logic               obj_on_next;
    logic [2:0]         sync_pipe [LATENCY];

    assign obj_in[0] = p_obj1;
    assign obj_in[1] = p_obj2;
    assign obj_in[2] = p_obj3;
    assign obj_in[3] = p_obj4;
    assign obj_in[4] = p_obj5;

    always_comb begin
        present_in = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            present_in[i] = |obj_in[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vsync_prev <= 1'b0;
            obj_count  <= '0;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                snap[i] <= '0;
            end
        end else begin
            vsync_prev <= vsync;
            if (vsync && !vsync_prev) begin
                obj_count <= count_present(present_in);
                for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                    snap[i] <= obj_in[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        obj_hit_test #(.OBJ_SIZE(OBJ_SIZE)) u_hit (
            .hcount (hcount),
            .vcount (vcount),
            .desc   (snap[g]),
            .hit    (hit[g]),
            .dx     (dx[g]),
            .dy     (dy[g])
        );
    end

    // Lowest index wins even if its ROM pixel later turns out transparent.
    always_comb begin
        hit_any  = 1'b0;
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (hit[i] && !hit_any) begin
                hit_any  = 1'b1;
                win_addr = {snap[i][ID_MSB:ID_LSB], snap[i][FRAME_MSB:FRAME_LSB], dy[i], dx[i]};
            end
        end
    end

    assign obj_on_next = hit2 && !sync_pipe[1][0] && (rom_data != TRANSPARENT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hit1     <= 1'b0;
            hit2     <= 1'b0;
            rom_addr <= '0;
            obj_on   <= 1'b0;
            pixel    <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            hit1         <= hit_any;
            rom_addr     <= win_addr;
            hit2         <= hit1;
            obj_on       <= obj_on_next;
            pixel        <= obj_on_next ? rom_data : '0;
            sync_pipe[0] <= {hsync, vsync, blank};
            for (int unsigned i = 1; i < LATENCY; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign {hsync_out, vsync_out, blank_out} = sync_pipe[LATENCY-1];

endmodule

// File: tb/tb_obj_sprite_renderer.sv
// Directed bench for obj_sprite_renderer with a behavioural synchronous sprite ROM.
module tb_obj_sprite_renderer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank;
    logic [25:0] p_obj1, p_obj2, p_obj3, p_obj4, p_obj5;
    logic [14:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] pixel;
    logic        obj_on;
    logic        hsync_out, vsync_out, blank_out;
    logic [2:0]  obj_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [14:0] A_F80 = {2'd0, 3'd2, 5'd7, 5'd5};

    obj_sprite_renderer #(.OBJ_SIZE(20), .TRANSPARENT(12'h000), .LATENCY(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank     (blank),
        .p_obj1    (p_obj1),
        .p_obj2    (p_obj2),
        .p_obj3    (p_obj3),
        .p_obj4    (p_obj4),
        .p_obj5    (p_obj5),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pixel     (pixel),
        .obj_on    (obj_on),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .blank_out (blank_out),
        .obj_count (obj_count)
    );

    always #5 clock = ~clock;

    // Identity 3 is fully transparent; one address holds orange; the rest are opaque.
    function automatic logic [11:0] rom_fn(input logic [14:0] a);
        if (a[14:13] == 2'd3) return 12'h000;
        if (a == A_F80)       return 12'hF80;
        return {1'b1, a[10:0]};
    endfunction

    always @(posedge clock) rom_data <= rom_fn(rom_addr);

    function automatic logic [25:0] mk(input logic [2:0] fr, input logic [1:0] id,
                                       input logic [10:0] h, input logic [9:0] v);
        return {fr, id, h, v};
    endfunction

    function automatic logic [14:0] mka(input logic [1:0] id, input logic [2:0] fr,
                                        input logic [4:0] row, input logic [4:0] col);
        return {id, fr, row, col};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        hcount = 11'd600; vcount = 10'd10; hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
    endtask

    task automatic vsync_pulse();
        hcount = 11'd600; vcount = 10'd10; blank = 1'b1; vsync = 1'b1;
        tick();
        idle();
        tick(); tick(); tick();
    endtask

    // One pixel sample followed by idle clocks: rom_addr after 1 edge, output after 3.
    task automatic sample(input string tag, input logic [10:0] h, input logic [9:0] v,
                          input logic bl, input logic [14:0] exp_addr, input logic exp_on);
        hcount = h; vcount = v; blank = bl;
        tick();
        check_eq({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        idle();
        tick();
        check_eq({tag, ".early"}, 32'(obj_on), 32'd0);
        tick();
        check_eq({tag, ".on"}, 32'(obj_on), 32'(exp_on));
        check_eq({tag, ".pix"}, 32'(pixel), exp_on ? 32'(rom_fn(exp_addr)) : 32'd0);
    endtask

    logic [2:0] hist [64];

    initial begin
        reset_n = 1'b0;
        hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        p_obj1 = '0; p_obj2 = '0; p_obj3 = '0; p_obj4 = '0; p_obj5 = '0;
        tick(); tick();
        check_eq("rst.pix", 32'(pixel), 32'd0);
        check_eq("rst.on", 32'(obj_on), 32'd0);
        check_eq("rst.addr", 32'(rom_addr), 32'd0);
        check_eq("rst.cnt", 32'(obj_count), 32'd0);
        check_eq("rst.syncs", 32'({hsync_out, vsync_out, blank_out}), 32'd0);
        reset_n = 1'b1;

        // Empty snapshot: outputs stay dark and syncs come out three registers later.
        for (int i = 0; i < 40; i++) begin
            hist[i] = 3'(i * 5 + (i >> 2));
            {hsync, vsync, blank} = hist[i];
            hcount = 11'(i * 3); vcount = 10'd300;
            tick();
            check_eq("empty.on", 32'(obj_on), 32'd0);
            check_eq("empty.pix", 32'(pixel), 32'd0);
            check_eq("empty.cnt", 32'(obj_count), 32'd0);
            if (i >= 2)
                check_eq("empty.syncs", 32'({hsync_out, vsync_out, blank_out}), 32'(hist[i-2]));
        end
        idle();
        tick(); tick(); tick();

        p_obj1 = mk(3'd2, 2'd0, 11'd100, 10'd300);
        vsync_pulse();
        check_eq("single.cnt", 32'(obj_count), 32'd1);
        sample("single", 11'd105, 10'd307, 1'b0, A_F80, 1'b1);

        sample("edge.r_in",  11'd119, 10'd307, 1'b0, mka(2'd0, 3'd2, 5'd7, 5'd19), 1'b1);
        sample("edge.b_in",  11'd105, 10'd319, 1'b0, mka(2'd0, 3'd2, 5'd19, 5'd5), 1'b1);
        sample("edge.r_out", 11'd120, 10'd307, 1'b0, 15'd0, 1'b0);
        sample("edge.l_out", 11'd99,  10'd307, 1'b0, 15'd0, 1'b0);
        sample("edge.b_out", 11'd105, 10'd320, 1'b0, 15'd0, 1'b0);

        p_obj2 = mk(3'd1, 2'd3, 11'd200, 10'd300);
        p_obj4 = mk(3'd4, 2'd1, 11'd200, 10'd300);
        p_obj5 = mk(3'd0, 2'd1, 11'd2040, 10'd300);
        vsync_pulse();
        check_eq("prio.cnt", 32'(obj_count), 32'd4);
        sample("prio", 11'd210, 10'd305, 1'b0, mka(2'd3, 3'd1, 5'd5, 5'd10), 1'b0);
        sample("nowrap", 11'd3, 10'd307, 1'b0, 15'd0, 1'b0);
        sample("rightmost", 11'd2045, 10'd307, 1'b0, mka(2'd1, 3'd0, 5'd7, 5'd5), 1'b1);

        p_obj2 = '0; p_obj4 = '0; p_obj5 = '0;
        vsync_pulse();
        check_eq("hold.cnt0", 32'(obj_count), 32'd1);
        p_obj1 = mk(3'd2, 2'd0, 11'd50, 10'd300);
        p_obj3 = mk(3'd0, 2'd1, 11'd700, 10'd100);
        sample("hold.old", 11'd105, 10'd307, 1'b0, A_F80, 1'b1);
        sample("hold.new_early", 11'd55, 10'd307, 1'b0, 15'd0, 1'b0);
        check_eq("hold.cnt1", 32'(obj_count), 32'd1);
        vsync_pulse();
        check_eq("hold.cnt2", 32'(obj_count), 32'd2);
        sample("hold.new", 11'd55, 10'd307, 1'b0, A_F80, 1'b1);
        sample("hold.old_gone", 11'd105, 10'd307, 1'b0, 15'd0, 1'b0);

        p_obj1 = mk(3'd2, 2'd0, 11'd100, 10'd300);
        p_obj3 = '0;
        vsync_pulse();
        sample("blank", 11'd105, 10'd307, 1'b1, A_F80, 1'b0);
        sample("pre_rst", 11'd105, 10'd307, 1'b0, A_F80, 1'b1);
        reset_n = 1'b0; hcount = 11'd500;
        tick();
        check_eq("mid_rst.pix", 32'(pixel), 32'd0);
        check_eq("mid_rst.on", 32'(obj_on), 32'd0);
        check_eq("mid_rst.cnt", 32'(obj_count), 32'd0);
        reset_n = 1'b1;
        idle();
        tick();
        sample("post_rst", 11'd105, 10'd307, 1'b0, 15'd0, 1'b0);
        vsync_pulse();
        check_eq("reload.cnt", 32'(obj_count), 32'd1);
        sample("reload", 11'd105, 10'd307, 1'b0, A_F80, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
